// File: rtl/blink_scheduler_if.sv
// Configuration write channel of the blink scheduler: valid/ready plus channel select and interval.
// Latency: none, plain wires bundled for port grouping.
// Backpressure: ready is driven by the scheduler; the initiator holds valid/sel/interval while offering.
interface blink_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_interval;

    modport master (output cfg_valid, cfg_sel, cfg_interval, input cfg_ready);
    modport slave  (input cfg_valid, cfg_sel, cfg_interval, output cfg_ready);
endinterface

// File: rtl/blink_scheduler.sv
// Three-channel LED blink scheduler: IDLE/RUN FSM, shadowed per-channel intervals, LFSR-randomised channel 2.
// Latency: start/stop act at the next edge; a channel pulses one cycle after its counter reaches its interval.
// Backpressure: none; cfg_ready follows reset release and every offered write is taken in that cycle.
module blink_scheduler #(
    parameter int         CNT_W     = 4,     // interval/counter width, at most 8 (channel 2 draws from an 8-bit LFSR)
    parameter logic [7:0] LFSR_SEED = 8'hA5  // must be nonzero, an all-zero LFSR never leaves zero
) (
    input  logic             clk,
    input  logic             rstbtn_n,
    input  logic             start,
    input  logic             stop,
    input  logic             rand_en,
    blink_scheduler_if.slave cfg,
    output logic [2:0]       led,
    output logic             busy
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] act_q [3];
    logic [CNT_W-1:0] act_d [3];
    logic [CNT_W-1:0] shd_q [3];
    logic [CNT_W-1:0] shd_d [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       led_d;
    logic [2:0]       hit;
    logic [2:0]       wr_hit;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] lfsr_pick;
    logic             enter;
    logic             running;

    // Ready is purely a function of reset so it drops the instant reset is asserted.
    assign cfg.cfg_ready = rstbtn_n;

    assign enter     = (state_q == IDLE) && (state_d == RUN);
    assign running   = (state_q == RUN) && !stop;
    // A zero interval would disable channel 2, so a zero draw is bumped to 1.
    assign lfsr_pick = (lfsr_q[CNT_W-1:0] == '0) ? CNT_W'(1) : lfsr_q[CNT_W-1:0];

    // Next-state: stop wins over start, start is meaningless while running.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // LFSR taps 8,6,5,4; free-runs only while in RUN so IDLE keeps the sequence position.
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == RUN) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Per-channel counter/interval update; interval swaps only at pulse edges so a period always completes.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hit[i]    = (cnt_q[i] == act_q[i]) && (act_q[i] != '0);
            wr_hit[i] = cfg.cfg_valid && (cfg.cfg_sel == 2'(i));
            shd_d[i]  = wr_hit[i] ? cfg.cfg_interval : shd_q[i];
            act_d[i]  = act_q[i];
            cnt_d[i]  = '0;
            led_d[i]  = 1'b0;
            if (state_q == IDLE) begin
                if (wr_hit[i]) act_d[i] = cfg.cfg_interval;
            end else if (running) begin
                if (hit[i]) begin
                    led_d[i] = 1'b1;
                    act_d[i] = shd_q[i];
                end else if (act_q[i] == '0) begin
                    act_d[i] = shd_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Random mode replaces the shadow value as channel 2's interval source.
        if (rand_en && (enter || (running && (hit[2] || act_q[2] == '0)))) act_d[2] = lfsr_pick;
    end

    // State, datapath and registered outputs; reset restores power-up intervals.
    always_ff @(posedge clk or negedge rstbtn_n) begin
        if (!rstbtn_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            led     <= 3'b000;
            lfsr_q  <= LFSR_SEED;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            act_q[0] <= CNT_W'(9);
            shd_q[0] <= CNT_W'(9);
            act_q[1] <= CNT_W'(4);
            shd_q[1] <= CNT_W'(4);
            act_q[2] <= '0;
            shd_q[2] <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN);
            led     <= led_d;
            lfsr_q  <= lfsr_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
        end
    end
endmodule

// File: tb/tb_blink_scheduler.sv
// Self-checking bench for blink_scheduler: directed scenarios plus a random run against a pulse-schedule model.
// Latency: model predicts outputs of the cycle following each driven cycle.
// Backpressure: cfg_ready is expected high whenever reset is released.
module tb_blink_scheduler;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rstbtn_n;
    logic       start;
    logic       stop;
    logic       rand_en;
    logic [2:0] led;
    logic       busy;

    blink_scheduler_if #(.CNT_W(CNT_W)) cfg_if ();

    blink_scheduler #(.CNT_W(CNT_W), .LFSR_SEED(8'hA5)) dut (
        .clk      (clk),
        .rstbtn_n (rstbtn_n),
        .start    (start),
        .stop     (stop),
        .rand_en  (rand_en),
        .cfg      (cfg_if),
        .led      (led),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: per channel the active/shadow interval and the absolute cycle of its next pulse.
    bit       m_run;
    bit [2:0] m_led;
    int       m_a   [3];
    int       m_s   [3];
    int       m_due [3];
    bit [7:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit [7:0] lfsr_next(input bit [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int pick(input bit [7:0] l);
        return (l[3:0] == 4'd0) ? 1 : int'(l[3:0]);
    endfunction

    function automatic void model_reset();
        m_run  = 1'b0;
        m_led  = 3'b000;
        m_a    = '{9, 4, 0};
        m_s    = '{9, 4, 0};
        m_due  = '{0, 0, 0};
        m_lfsr = 8'hA5;
    endfunction

    // Advance the model across the edge ending the current cycle.
    function automatic void model_edge(input bit st, input bit sp, input bit cv, input bit [1:0] cs,
                                       input bit [3:0] ci, input bit re);
        int       nxt;
        int       src;
        bit [2:0] led_n;
        nxt   = cyc + 1;
        led_n = 3'b000;
        if (m_run) begin
            if (!sp) begin
                for (int i = 0; i < 3; i++) begin
                    src = (i == 2 && re) ? pick(m_lfsr) : m_s[i];
                    if (m_a[i] != 0 && m_due[i] == nxt) begin
                        led_n[i] = 1'b1;
                        m_a[i]   = src;
                        m_due[i] = nxt + src + 1;
                    end else if (m_a[i] == 0) begin
                        m_a[i]   = src;
                        m_due[i] = nxt + src + 1;
                    end
                end
            end else begin
                m_run = 1'b0;
            end
            m_lfsr = lfsr_next(m_lfsr);
            for (int i = 0; i < 3; i++) if (cv && cs == 2'(i)) m_s[i] = int'(ci);
        end else begin
            for (int i = 0; i < 3; i++) if (cv && cs == 2'(i)) begin
                m_s[i] = int'(ci);
                m_a[i] = int'(ci);
            end
            if (st && !sp) begin
                m_run = 1'b1;
                if (re) m_a[2] = pick(m_lfsr);
                for (int i = 0; i < 3; i++) m_due[i] = nxt + m_a[i] + 1;
            end
        end
        m_led = led_n;
    endfunction

    // Drive one cycle of inputs, step the model, then compare the following cycle's outputs.
    task automatic tick(input bit st, input bit sp, input bit cv, input bit [1:0] cs,
                        input bit [3:0] ci, input bit re);
        start               = st;
        stop                = sp;
        rand_en             = re;
        cfg_if.cfg_valid    = cv;
        cfg_if.cfg_sel      = cs;
        cfg_if.cfg_interval = ci;
        model_edge(st, sp, cv, cs, ci, re);
        @(posedge clk);
        #1;
        cyc++;
        chk("led", 32'(led), 32'(m_led));
        chk("busy", 32'(busy), 32'(m_run));
        chk("ready", 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    task automatic idle(input int n, input bit re);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, re);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  last;
        int  gap;
        bit  found;
        bit  re;

        rstbtn_n            = 1'b0;
        start               = 1'b0;
        stop                = 1'b0;
        rand_en             = 1'b0;
        cfg_if.cfg_valid    = 1'b0;
        cfg_if.cfg_sel      = 2'd0;
        cfg_if.cfg_interval = 4'd0;
        model_reset();

        // Reset state
        #2;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rstbtn_n = 1'b1;
        #1 chk("rel_ready", 32'(cfg_if.cfg_ready), 32'd1);
        idle(3, 1'b0);

        // Default intervals: ch0 every 10, ch1 every 5, ch2 disabled
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("busy_c0", 32'(busy), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            if (k == 5 || k == 15) chk("dflt_ch1", 32'(led), 32'd2);
            if (k == 10 || k == 20 || k == 30) chk("dflt_both", 32'(led), 32'd3);
        end

        // Shadow write mid-run lets the current period finish
        tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) tick(1'b0, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0);
            else        tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            if (k == 10 || k == 13 || k == 16 || k == 19) chk("shadow_pulse", 32'(led[0]), 32'd1);
            if (k == 11 || k == 12 || k == 14) chk("shadow_quiet", 32'(led[0]), 32'd0);
        end

        // Start and stop together in IDLE
        tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("both_busy", 32'(busy), 32'd0);
        chk("both_led", 32'(led), 32'd0);

        // Stop at cycle 7, restart from zeroed counters
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        idle(7, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("stop_busy", 32'(busy), 32'd0);
        idle(2, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            if (k == 4) chk("restart_early", 32'(led[1]), 32'd0);
            if (k == 5) chk("restart_pulse", 32'(led[1]), 32'd1);
        end

        // Random channel-2 intervals: every gap must be 2..16 cycles
        tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
        last = cyc;
        for (int k = 0; k < 300; k++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
            if (led[2] === 1'b1) begin
                gap = cyc - last;
                chk("rand_gap", 32'(gap >= 2 && gap <= 16), 32'd1);
                last = cyc;
            end
        end
        idle(40, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);

        // Random traffic against the model
        re = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 63) == 0) re = ~re;
            tick(bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 39) == 0),
                 bit'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), re);
        end

        // Reset mid-pulse: outputs drop at once, power-up behaviour afterwards
        tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'd0, 4'd3, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!found) begin
                tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
                if (m_led[0]) found = 1'b1;
            end
        end
        chk("pulse_found", 32'(found), 32'd1);
        #2 rstbtn_n = 1'b0;
        #1;
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #3 rstbtn_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
            if (k == 5) chk("post_rst_ch1", 32'(led), 32'd2);
            if (k == 10) chk("post_rst_both", 32'(led), 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/blink_scheduler.md
BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 Parameter CNT_W, default 4: width of interval registers and cycle counters.
REQ-002 Parameter LFSR_SEED, default 8'hA5: LFSR reset value; SHALL be nonzero.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rstbtn_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request transition IDLE -> RUN.
REQ-006 stop  input  1  request transition RUN -> IDLE.
REQ-007 cfg_valid  input  1  configuration write request.
REQ-008 cfg_ready  output  1  configuration write can be accepted.
REQ-009 cfg_sel  input  2  target channel, 0..2; value 3 is reserved.
REQ-010 cfg_interval  input  CNT_W  new blink interval for the selected channel.
REQ-011 rand_en  input  1  channel 2 takes its interval from the LFSR.
REQ-012 led  output  3  one-cycle blink pulses, one bit per channel.
REQ-013 busy  output  1  high when the FSM is in RUN.

Function
REQ-014 FSM SHALL have two states. IDLE: counters held at 0, led=0. RUN: counters advance.
REQ-015 IDLE with start=1 SHALL enter RUN at the next edge.
REQ-016 RUN with stop=1 SHALL enter IDLE at the next edge and clear all counters and led bits.
REQ-017 When start and stop are high in the same cycle, stop SHALL take priority; start is ignored.
REQ-018 Each channel SHALL hold an active interval A and a shadow interval S, both CNT_W bits wide.
REQ-019 In RUN, each channel counter SHALL increment by 1 per cycle while counter != A.
REQ-020 When counter == A and A != 0:
  - the counter SHALL load 0 at the next edge;
  - the channel's led bit SHALL be 1 for exactly that next cycle.
REQ-021 Timing of REQ-020:
  - cycle 0 is the first RUN cycle;
  - led pulses in cycles A+1, 2(A+1), ...;
  - period is A+1 cycles.
REQ-022 When A == 0, the channel is disabled: counter held at 0, led bit 0.
REQ-023 Counter SHALL never exceed A; no modulo arithmetic is used; no wrap past 2^CNT_W-1 is possible.
REQ-024 cfg_ready SHALL be 1 whenever rstbtn_n is high; every write with cfg_valid=1 and cfg_sel<=2 is accepted in that cycle.
REQ-025 An accepted write SHALL load S of the selected channel at the next edge.
REQ-026 A write with cfg_sel=3 SHALL be accepted with no state change.
REQ-027 In IDLE, a written S SHALL also be copied into A at the same edge.
REQ-028 In RUN, A SHALL load S at the edge where that channel pulses, so the current period always completes.
REQ-029 In RUN, if the channel's A==0, S SHALL be copied into A at the next edge, with the counter at 0.
REQ-030 Two writes to the same channel before S is applied: the last write SHALL win.
REQ-031 LFSR: 8-bit Fibonacci, taps 8,6,5,4 (feedback = q[7]^q[5]^q[4]^q[3], shifted into q[0]).
REQ-032 The LFSR SHALL advance every cycle in RUN and hold in IDLE.
REQ-033 When rand_en=1, channel 2 SHALL ignore S2. At RUN entry and at every channel-2 pulse edge, A2 SHALL load the low CNT_W LFSR bits, with value 0 replaced by 1.
REQ-034 When rand_en falls, A2 SHALL load S2 at the next channel-2 pulse edge.
REQ-035 led and busy SHALL be registered outputs with no combinational path from any input.

Reset
REQ-036 rstbtn_n=0 SHALL immediately and asynchronously force the following values:
  - FSM state = IDLE;
  - counters = 0;
  - led = 3'b000; busy = 0; cfg_ready = 0;
  - LFSR = LFSR_SEED;
  - A0 = S0 = 9; A1 = S1 = 4; A2 = S2 = 0.
REQ-037 Reset asserted mid-RUN SHALL abort without any further pulse; operation after release SHALL be identical to power-up.
REQ-038 Release of rstbtn_n SHALL take effect at the first clk edge after release; start sampled at that edge is honoured.

Verification
REQ-039 Reset, pulse start, rand_en=0 -> led[0] high in cycles 10, 20, 30; led[1] in cycles 5, 10, 15; led[2] never; busy=1 from cycle 0.
REQ-040 In RUN, write ch0=2 in cycle 3 -> led[0] at cycle 10 unchanged, then cycles 13, 16, 19.
REQ-041 start and stop high together in IDLE -> remains IDLE; busy=0; led=0.
REQ-042 In RUN, stop at cycle 7 -> IDLE next cycle, counters 0; restart -> led[1] first pulse 5 cycles after RUN entry.
REQ-043 rand_en=1, seed A5 -> A2 always in 1..15; inter-pulse gaps on led[2] match a reference LFSR model; no pulse while A2 would be 0.
REQ-044 Assert rstbtn_n low mid-cycle during a led[0] pulse -> led drops to 0 before the next edge; all REQ-036 values restored.
